// File: rtl/capture_sequencer.sv
// capture_sequencer: ring-buffered triggered ADC capture, streamed as one SD sector.
// Optional CAPTURE_STATS_EN adds capture_count and drop_count outputs.
module capture_sequencer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int SECTOR_BYTES      = 512,
  parameter int PRE_SAMPLES       = 128,
  parameter int BASE_BLOCK        = 1,
  parameter int NUM_BLOCKS        = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                         trigger,
  input  logic                         sd_ready,
  output logic                         sd_wr_start,
  output logic [31:0]                  sd_wr_addr,
  output logic [SAMPLE_DATA_WIDTH-1:0] sd_wr_data,
  output logic                         sd_wr_valid,
  input  logic                         sd_wr_ready,
  input  logic                         sd_wr_done,
  input  logic                         sd_wr_err,
  output logic                         armed,
  output logic                         busy,
  output logic                         error
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0]                  capture_count,
  output logic [15:0]                  drop_count
`endif
);

  localparam int AW   = $clog2(SECTOR_BYTES);
  localparam int CW   = $clog2(SECTOR_BYTES + 1);
  localparam int POST = SECTOR_BYTES - PRE_SAMPLES;
  localparam logic [31:0] ADDR_FIRST = 32'(BASE_BLOCK);
  localparam logic [31:0] ADDR_LAST  = 32'(BASE_BLOCK + NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITE_CMD,
    WRITE_DATA,
    WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic                         trig_q;
  logic                         trig_edge;
  logic                         take;
  logic                         ring_we;
  logic                         xfer;
  logic                         last_xfer;
  logic                         fail;
  logic                         done_ok;
  logic                         rd_en;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [AW-1:0]                start_ptr;
  logic [AW-1:0]                rd_addr;
  logic [CW-1:0]                fill;
  logic [CW-1:0]                post_cnt;
  logic [CW-1:0]                sent;
  logic [SAMPLE_DATA_WIDTH-1:0] ram [SECTOR_BYTES];
  logic [SAMPLE_DATA_WIDTH-1:0] rd_q;
  logic                         valid_q;
  logic                         err_q;
  logic [31:0]                  addr_q;

  assign sd_wr_addr  = addr_q;
  assign sd_wr_data  = rd_q;
  assign sd_wr_valid = valid_q;
  assign error       = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take)
          state_nx = (axiiv && POST == 1) ? WRITE_CMD : CAPTURE;
      end
      CAPTURE: begin
        if (axiiv && post_cnt == CW'(1))
          state_nx = WRITE_CMD;
      end
      WRITE_CMD: begin
        if (sd_ready) state_nx = WRITE_DATA;
      end
      WRITE_DATA: begin
        if (fail)           state_nx = IDLE;
        else if (last_xfer) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fail || sd_wr_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy        = (state != IDLE);
    armed       = (state == IDLE) && (fill >= CW'(PRE_SAMPLES));
    sd_wr_start = (state == WRITE_CMD) && sd_ready;
    ring_we     = axiiv && ((state == IDLE) || (state == CAPTURE));
  end

  // Handshake qualifiers and read-port steering
  always_comb begin
    trig_edge = trigger && !trig_q;
    take      = trig_edge && armed;
    xfer      = (state == WRITE_DATA) && valid_q && sd_wr_ready;
    last_xfer = xfer && (sent == CW'(SECTOR_BYTES - 1));
    fail      = sd_wr_err &&
                ((state == WRITE_DATA) || (state == WAIT_DONE));
    done_ok   = (state == WAIT_DONE) && sd_wr_done && !sd_wr_err;
    rd_en     = sd_wr_start || (xfer && !last_xfer && !fail);
    rd_addr   = sd_wr_start ? start_ptr : rd_ptr;
  end

  // Capture bookkeeping, stream counters, address and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q    <= 1'b0;
      wr_ptr    <= '0;
      fill      <= '0;
      start_ptr <= '0;
      post_cnt  <= '0;
      rd_ptr    <= '0;
      sent      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= ADDR_FIRST;
    end else begin
      trig_q <= trigger;
      if (ring_we) wr_ptr <= wr_ptr + AW'(1);
      if (done_ok)
        fill <= '0;
      else if (ring_we && fill != CW'(SECTOR_BYTES))
        fill <= fill + CW'(1);
      if (take) begin
        start_ptr <= wr_ptr - AW'(PRE_SAMPLES);
        post_cnt  <= axiiv ? CW'(POST - 1) : CW'(POST);
      end else if (state == CAPTURE && axiiv) begin
        post_cnt <= post_cnt - CW'(1);
      end
      if (sd_wr_start)
        rd_ptr <= start_ptr + AW'(1);
      else if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      if (sd_wr_start)
        sent <= '0;
      else if (xfer)
        sent <= sent + CW'(1);
      if (fail)
        valid_q <= 1'b0;
      else if (sd_wr_start)
        valid_q <= 1'b1;
      else if (last_xfer)
        valid_q <= 1'b0;
      if (fail) err_q <= 1'b1;
      if (done_ok)
        addr_q <= (addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + 32'd1;
    end
  end

  // Ring write port
  always_ff @(posedge clk) begin
    if (ring_we) ram[wr_ptr] <= axiid;
  end

  // Ring read port; holds the presented byte until the next fetch
  always_ff @(posedge clk) begin
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= ram[rd_addr];
  end

`ifdef CAPTURE_STATS_EN
  // Completed-sector and dropped-sample counters
  always_ff @(posedge clk) begin
    if (rst) begin
      capture_count <= '0;
      drop_count    <= '0;
    end else begin
      if (done_ok) capture_count <= capture_count + 16'd1;
      if (axiiv && busy && state != CAPTURE && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed + randomized checks of capture_sequencer
// against a sample-stream reference model.
module tb_capture_sequencer;

  localparam int SECTOR = 512;
  localparam int PRE    = 128;
  localparam int POST   = SECTOR - PRE;
  localparam int BASE   = 1;
  localparam int NBLK   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        trigger;
  logic        sd_ready;
  logic        sd_wr_start;
  logic [31:0] sd_wr_addr;
  logic [7:0]  sd_wr_data;
  logic        sd_wr_valid;
  logic        sd_wr_ready;
  logic        sd_wr_done;
  logic        sd_wr_err;
  logic        armed;
  logic        busy;
  logic        error;
`ifdef CAPTURE_STATS_EN
  logic [15:0] capture_count;
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  capture_sequencer #(
    .SAMPLE_DATA_WIDTH(8),
    .SECTOR_BYTES(SECTOR),
    .PRE_SAMPLES(PRE),
    .BASE_BLOCK(BASE),
    .NUM_BLOCKS(NBLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .trigger(trigger),
    .sd_ready(sd_ready),
    .sd_wr_start(sd_wr_start),
    .sd_wr_addr(sd_wr_addr),
    .sd_wr_data(sd_wr_data),
    .sd_wr_valid(sd_wr_valid),
    .sd_wr_ready(sd_wr_ready),
    .sd_wr_done(sd_wr_done),
    .sd_wr_err(sd_wr_err),
    .armed(armed),
    .busy(busy),
    .error(error)
`ifdef CAPTURE_STATS_EN
    ,
    .capture_count(capture_count),
    .drop_count(drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: sample history since last clear, captured sector
  typedef enum {M_IDLE, M_CAP, M_WR} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [7:0] hist[$];
  logic [7:0] exp_sector[$];
  int         post_left = 0;
  int         m_addr = BASE;
  int         m_drops = 0;
  int         m_caps = 0;
  int         exp_start_addr = 0;
  bit         m_err = 1'b0;
  bit         m_prev_trg = 1'b0;

  // Monitor: accepted bytes, start pulses, hold stability, first-byte latency
  logic [7:0] got[$];
  int         starts = 0;
  int         last_start_addr = 0;
  bit         hold = 1'b0;
  logic [7:0] hold_d;
  bit         lat_run = 1'b0;
  int         lat = 0;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
      lat_run = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(sd_wr_valid), 1);
        chk("hold_data", 32'(sd_wr_data), 32'(hold_d));
      end
      if (lat_run) begin
        lat++;
        if (sd_wr_valid || lat > 2) begin
          chk("first_byte_latency", 32'(sd_wr_valid && lat <= 2), 1);
          lat_run = 1'b0;
        end
      end
      if (sd_wr_start) begin
        starts++;
        last_start_addr = int'(sd_wr_addr);
        lat_run = 1'b1;
        lat = 0;
      end
      if (sd_wr_valid && sd_wr_ready) got.push_back(sd_wr_data);
      hold = sd_wr_valid && !sd_wr_ready && !sd_wr_err;
      hold_d = sd_wr_data;
    end
  end

  task automatic model_step(input bit v, input logic [7:0] d, input bit trg,
                            input bit dn, input bit er, input bit rs);
    bit edge_seen;
    if (rs) begin
      m_mode = M_IDLE;
      hist.delete();
      m_addr = BASE;
      m_err = 1'b0;
      m_drops = 0;
      m_caps = 0;
      m_prev_trg = 1'b0;
      return;
    end
    edge_seen = trg && !m_prev_trg;
    m_prev_trg = trg;
    case (m_mode)
      M_IDLE: begin
        if (edge_seen && hist.size() >= PRE) begin
          exp_sector.delete();
          for (int i = hist.size() - PRE; i < hist.size(); i++)
            exp_sector.push_back(hist[i]);
          post_left = POST;
          m_mode = M_CAP;
        end
      end
      default: ;
    endcase
    if (m_mode == M_IDLE) begin
      if (v) hist.push_back(d);
    end else if (m_mode == M_CAP) begin
      if (v) begin
        hist.push_back(d);
        exp_sector.push_back(d);
        post_left--;
        if (post_left == 0) begin
          m_mode = M_WR;
          exp_start_addr = m_addr;
        end
      end
    end else begin
      if (v) m_drops++;
      if (er) begin
        m_mode = M_IDLE;
        m_err = 1'b1;
      end else if (dn) begin
        m_mode = M_IDLE;
        hist.delete();
        m_caps++;
        m_addr = (m_addr == BASE + NBLK - 1) ? BASE : m_addr + 1;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit trg,
                     input bit rdy, input bit sdr, input bit dn,
                     input bit er, input bit rs);
    axiiv = v;
    axiid = d;
    trigger = trg;
    sd_wr_ready = rdy;
    sd_ready = sdr;
    sd_wr_done = dn;
    sd_wr_err = er;
    rst = rs;
    model_step(v, d, trg, dn, er, rs);
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("armed", 32'(armed), 32'(m_mode == M_IDLE && hist.size() >= PRE));
    chk("error", 32'(error), 32'(m_err));
    chk("addr", sd_wr_addr, 32'(m_addr));
`ifdef CAPTURE_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("capture_count", 32'(capture_count), 32'(m_caps));
`endif
  endtask

  task automatic reset_dut();
    cyc(0, 8'd0, 0, 0, 0, 0, 0, 1);
    chk("rst_start", 32'(sd_wr_start), 0);
    chk("rst_valid", 32'(sd_wr_valid), 0);
    chk("rst_data", 32'(sd_wr_data), 0);
    chk("rst_addr", sd_wr_addr, BASE);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
  endtask

  task automatic rand_capture(input int err_at, input int rst_at);
    int n = 0;
    int st0 = starts;
    int bad = 0;
    bit fin = 1'b0;
    bit trg = trigger;
    bit wr, v, dn, er, rs;
    logic [7:0] d;
    got.delete();
    while (!fin && n < 20000) begin
      v = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      if ($urandom_range(0, 11) == 0) trg = !trg;
      dn = 1'b0;
      er = 1'b0;
      rs = 1'b0;
      wr = (m_mode == M_WR);
      if (wr && err_at > 0 && got.size() >= err_at) er = 1'b1;
      else if (wr && rst_at > 0 && got.size() >= rst_at) rs = 1'b1;
      else if (wr && got.size() == SECTOR) dn = 1'b1;
      cyc(v, d, trg, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, dn, er, rs);
      if (dn || er || rs) fin = 1'b1;
      n++;
    end
    chk("capture_finished", 32'(fin), 1);
    chk("starts", starts - st0, 1);
    chk("start_addr", last_start_addr, exp_start_addr);
    if (dn) chk("accepts", got.size(), SECTOR);
    for (int i = 0; i < got.size() && i < exp_sector.size(); i++)
      if (got[i] !== exp_sector[i]) bad++;
    chk("sector_bytes_bad", bad, 0);
  endtask

  initial begin
    int st0;
    int n;
    int k;
    rst = 1'b1;
    axiiv = 1'b0;
    axiid = 8'd0;
    trigger = 1'b0;
    sd_ready = 1'b0;
    sd_wr_ready = 1'b0;
    sd_wr_done = 1'b0;
    sd_wr_err = 1'b0;
    @(posedge clk);
    #1;
    reset_dut();

    // Too few samples: trigger ignored
    st0 = starts;
    for (int i = 0; i < 100; i++) cyc(1, 8'(i), 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 1, 1, 1, 0, 0, 0);
    chk("unarmed_starts", starts - st0, 0);
    chk("unarmed_busy", 32'(busy), 0);
    chk("unarmed_armed", 32'(armed), 0);
    cyc(0, 8'd0, 0, 1, 1, 0, 0, 0);

    // Ramp capture with trigger right after sample 300
    reset_dut();
    got.delete();
    st0 = starts;
    for (int i = 0; i <= 300; i++) cyc(1, 8'(i), 0, 1, 1, 0, 0, 0);
    cyc(0, 8'd0, 1, 1, 1, 0, 0, 0);
    n = 301;
    k = 0;
    while (!(m_mode == M_WR && got.size() == SECTOR) && k < 3000) begin
      cyc(1, 8'(n), 1, 1, 1, 0, 0, 0);
      n++;
      k++;
    end
    chk("ramp_reached_end", 32'(got.size()), SECTOR);
    cyc(0, 8'd0, 1, 1, 1, 1, 0, 0);
    chk("ramp_starts", starts - st0, 1);
    chk("ramp_start_addr", last_start_addr, 1);
    chk("ramp_byte0", 32'(got[0]), 173);
    chk("ramp_byte128", 32'(got[128]), 45);
    chk("ramp_byte511", 32'(got[511]), 172);
    chk("ramp_busy_after_done", 32'(busy), 0);
    chk("ramp_next_addr", sd_wr_addr, 2);

    // Backpressure, retrigger and drops; address wraps after block 2
    rand_capture(0, 0);
    chk("bp_start_addr", last_start_addr, 2);
    for (int i = 0; i < 10; i++) cyc(0, 8'd0, 0, 1, 1, 0, 0, 0);
    chk("bp_accepts_after_idle", got.size(), SECTOR);
    chk("bp_valid_idle", 32'(sd_wr_valid), 0);
    chk("bp_wrapped_addr", sd_wr_addr, 1);

    // Write error mid-stream: sticky flag, same block retried
    rand_capture(200, 0);
    chk("err_flag", 32'(error), 1);
    chk("err_valid", 32'(sd_wr_valid), 0);
    chk("err_addr_held", sd_wr_addr, 1);
    rand_capture(0, 0);
    chk("retry_same_block", last_start_addr, 1);
    chk("err_still_set", 32'(error), 1);
    reset_dut();
    chk("err_cleared", 32'(error), 0);

    // Reset in the middle of a stream
    rand_capture(0, 100);
    chk("midrst_valid", 32'(sd_wr_valid), 0);
    chk("midrst_start", 32'(sd_wr_start), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", sd_wr_addr, 1);
    rand_capture(0, 0);
    chk("after_rst_addr", last_start_addr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
